fsm_group_ctrl: RTL and testbench

Parametrised control FSM that drives N child blocks over valid/ready handshakes and repeats the whole group a run-time number of times. It supersedes the fixed per-group enable and sequence controllers. One generic block covers both modes. In sequential mode it walks the children one at a time. In parallel mode it fires all children and tracks each one's completion independently. It sits between a parent controller (its `valid`/`ready`) and the child components or child controllers (`valid_child`/`ready_child`).

---
 rtl/fsm_pkg.sv | 14 +
 rtl/fsm_iter_counter.sv | 33 +++
 rtl/fsm_group_ctrl.sv | 103 ++++++++++
 tb/tb_fsm_group_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared types for the group-control FSM family: state encoding and child
// sequencing modes.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam int MODE_SEQ = 0;
    localparam int MODE_PAR = 1;

endpackage

// File: rtl/fsm_iter_counter.sv
// Group repeat counter: latches the requested iteration count at start and
// flags the final iteration so the controller can stop without wrapping.
module fsm_iter_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic          last
);

    logic [CW-1:0] r_limit;
    logic [CW-1:0] r_cnt;

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_limit <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_limit <= load_val;
            r_cnt   <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Compared before incrementing, so a limit of 2^CW-1 never needs a wrapped count.
    assign last = (r_cnt == r_limit - CW'(1));

endmodule

// File: rtl/fsm_group_ctrl.sv
// Drives N children over valid/ready, either one at a time (SEQ) or all at
// once with per-child completion tracking (PAR), repeating the group iters times.
module fsm_group_ctrl
    import fsm_pkg::*;
#(
    parameter int N    = 3,
    parameter int MODE = 0,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic [CW-1:0] iters,
    input  logic [N-1:0]  ready_child,
    output logic [N-1:0]  valid_child,
    output logic          ready
);

    fsm_state_t   r_state;
    fsm_state_t   w_state_nxt;
    logic         w_run;
    logic         w_start;
    logic         w_inc;
    logic         w_clear;
    logic         w_last;
    logic         w_iter_end;
    logic [N-1:0] w_en;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: defaults first so every path assigns each output; otherwise a latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_start     = (iters != '0);
                    w_state_nxt = (iters != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_iter_end) begin
                    if (w_last) w_state_nxt = DONE;
                    else        w_inc       = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_run       = (r_state == RUN);
    assign w_clear     = w_start | w_inc;
    assign valid_child = w_en;
    assign ready       = (r_state == DONE);

    fsm_iter_counter #(.CW(CW)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_start),
        .load_val (iters),
        .inc      (w_inc),
        .last     (w_last)
    );

    generate
        if (MODE == MODE_SEQ) begin : g_seq
            localparam int IW = (N > 1) ? $clog2(N) : 1;
            logic [IW-1:0] r_idx;
            logic          w_hit;
            logic          w_at_last;

            assign w_en       = w_run ? (N'(1) << r_idx) : '0;
            assign w_hit      = |(ready_child & w_en);
            assign w_at_last  = (r_idx == IW'(N - 1));
            assign w_iter_end = w_run & w_hit & w_at_last;

            always_ff @(posedge clk) begin
                if (reset || w_clear) r_idx <= '0;
                else if (w_run && w_hit && !w_at_last) r_idx <= r_idx + IW'(1);
            end
        end else begin : g_par
            logic [N-1:0] r_mask;
            logic [N-1:0] w_hits;

            // Dones from children whose enable is already low are masked out here.
            assign w_en       = w_run ? ~r_mask : '0;
            assign w_hits     = ready_child & w_en;
            assign w_iter_end = w_run & (&(r_mask | w_hits));

            always_ff @(posedge clk) begin
                if (reset || w_clear) r_mask <= '0;
                else if (w_run)       r_mask <= r_mask | w_hits;
            end
        end
    endgenerate

endmodule

// File: tb/tb_fsm_group_ctrl.sv
// Bench for fsm_group_ctrl: four instances (SEQ N=3, PAR N=4, SEQ N=2, PAR N=2)
// checked every cycle against a set-based model plus directed literal checks.
module tb_fsm_group_ctrl;

    typedef struct {
        int          st;    // 0 idle, 1 running, 2 done
        int          pos;   // sequential: child currently working
        logic [31:0] got;   // parallel: children finished this iteration
        int          it;    // iterations completed
        int          lim;   // iterations requested
    } mstate_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic armed = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0]        v_in;
    logic [3:0][7:0]   it_in;
    logic [3:0][31:0]  rc_in;
    logic [2:0]        vc0;
    logic [3:0]        vc1;
    logic [1:0]        vc2;
    logic [1:0]        vc3;
    logic [3:0]        rdy;
    logic [3:0][31:0]  vc_w;

    int      n_of[4]   = '{3, 4, 2, 2};
    bit      par_of[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    mstate_t ms[4];

    assign vc_w[0] = 32'(vc0);
    assign vc_w[1] = 32'(vc1);
    assign vc_w[2] = 32'(vc2);
    assign vc_w[3] = 32'(vc3);

    always #5 clk = ~clk;

    fsm_group_ctrl #(.N(3), .MODE(0), .CW(8)) u_d0 (
        .clk(clk), .reset(rst), .valid(v_in[0]), .iters(it_in[0]),
        .ready_child(rc_in[0][2:0]), .valid_child(vc0), .ready(rdy[0]));
    fsm_group_ctrl #(.N(4), .MODE(1), .CW(8)) u_d1 (
        .clk(clk), .reset(rst), .valid(v_in[1]), .iters(it_in[1]),
        .ready_child(rc_in[1][3:0]), .valid_child(vc1), .ready(rdy[1]));
    fsm_group_ctrl #(.N(2), .MODE(0), .CW(8)) u_d2 (
        .clk(clk), .reset(rst), .valid(v_in[2]), .iters(it_in[2]),
        .ready_child(rc_in[2][1:0]), .valid_child(vc2), .ready(rdy[2]));
    fsm_group_ctrl #(.N(2), .MODE(1), .CW(8)) u_d3 (
        .clk(clk), .reset(rst), .valid(v_in[3]), .iters(it_in[3]),
        .ready_child(rc_in[3][1:0]), .valid_child(vc3), .ready(rdy[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] full_mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    function automatic logic [31:0] m_en(input mstate_t s, input int n, input bit par);
        if (s.st != 1) return 32'h0;
        if (par) return full_mask(n) & ~s.got;
        return 32'h1 << s.pos;
    endfunction

    function automatic mstate_t m_next(input mstate_t s, input int n, input bit par, input bit r,
                                       input bit v, input int iters, input logic [31:0] rc);
        mstate_t     t;
        logic [31:0] en;
        bit          fin;
        t   = s;
        en  = m_en(s, n, par);
        fin = 1'b0;
        if (r) begin
            t.st = 0; t.pos = 0; t.got = '0; t.it = 0;
            return t;
        end
        case (s.st)
            0: if (v) begin
                if (iters == 0) t.st = 2;
                else begin
                    t.st = 1; t.pos = 0; t.got = '0; t.it = 0; t.lim = iters;
                end
            end
            1: begin
                if (!par) begin
                    if (rc[s.pos]) begin
                        if (s.pos < n - 1) t.pos = s.pos + 1;
                        else fin = 1'b1;
                    end
                end else begin
                    t.got = s.got | (rc & en);
                    fin   = (t.got == full_mask(n));
                end
                if (fin) begin
                    t.it  = s.it + 1;
                    t.pos = 0;
                    t.got = '0;
                    if (t.it == s.lim) t.st = 2;
                end
            end
            default: t.st = 0;
        endcase
        return t;
    endfunction

    initial for (int i = 0; i < 4; i++) ms[i] = '{0, 0, 32'h0, 0, 0};

    // Model state lives only in the bench, so blocking updates at the edge are race-free here.
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            ms[i] = m_next(ms[i], n_of[i], par_of[i], rst, v_in[i], int'(it_in[i]), rc_in[i]);

    always @(negedge clk)
        if (armed)
            for (int i = 0; i < 4; i++) begin
                check($sformatf("d%0d_valid_child", i), vc_w[i], m_en(ms[i], n_of[i], par_of[i]));
                check($sformatf("d%0d_ready", i), 32'(rdy[i]), 32'(ms[i].st == 2));
            end

    logic [3:0] t2_rc[5] = '{4'b0001, 4'b0000, 4'b0110, 4'b0001, 4'b1000};
    logic [3:0] t2_vc[5] = '{4'b1111, 4'b1110, 4'b1110, 4'b1000, 4'b1000};
    int         t6_exp[3] = '{3, 7, 11};

    initial begin
        int pulses;
        bit seen;
        v_in = '0; it_in = '0; rc_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_vc_d%0d", i), vc_w[i], 32'h0);
            check($sformatf("reset_ready_d%0d", i), 32'(rdy[i]), 32'h0);
        end

        // SEQ N=3, iters=1, children answer immediately.
        @(negedge clk); v_in[0] = 1'b1; it_in[0] = 8'd1;
        @(negedge clk); v_in[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("t1_vc_cycle%0d", c), vc_w[0], 32'h1 << (c - 1));
            check($sformatf("t1_noready_cycle%0d", c), 32'(rdy[0]), 32'h0);
            rc_in[0] = vc_w[0];
            @(negedge clk);
        end
        check("t1_ready_cycle4", 32'(rdy[0]), 32'h1);
        check("t1_vc_cycle4", vc_w[0], 32'h0);
        rc_in[0] = '0;
        @(negedge clk);
        check("t1_ready_cycle5", 32'(rdy[0]), 32'h0);

        // PAR N=4, iters=1, dones at cycles 1,3,3,5 plus a stale done at cycle 4.
        @(negedge clk); v_in[1] = 1'b1; it_in[1] = 8'd1;
        @(negedge clk); v_in[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t2_vc_cycle%0d", c + 1), vc_w[1], 32'(t2_vc[c]));
            rc_in[1] = 32'(t2_rc[c]);
            @(negedge clk);
        end
        check("t2_ready_cycle6", 32'(rdy[1]), 32'h1);
        check("t2_vc_cycle6", vc_w[1], 32'h0);
        rc_in[1] = '0;
        @(negedge clk);

        // SEQ N=2, iters=3; iters rewritten mid-run must be ignored.
        @(negedge clk); v_in[2] = 1'b1; it_in[2] = 8'd3;
        @(negedge clk); v_in[2] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("t3_vc_cycle%0d", c), vc_w[2], (c % 2 == 1) ? 32'h1 : 32'h2);
            if (c == 2) it_in[2] = 8'd7;
            rc_in[2] = vc_w[2];
            @(negedge clk);
        end
        check("t3_ready_cycle7", 32'(rdy[2]), 32'h1);
        rc_in[2] = '0;
        repeat (3) @(negedge clk);
        check("t3_idle_after", vc_w[2], 32'h0);

        // Stale dones in IDLE, then iters=0 start.
        rc_in[3] = 32'h3;
        repeat (3) @(negedge clk);
        check("t4_stale_idle_vc", vc_w[3], 32'h0);
        v_in[3] = 1'b1; it_in[3] = 8'd0;
        @(negedge clk); v_in[3] = 1'b0;
        check("t4_zero_ready", 32'(rdy[3]), 32'h1);
        check("t4_zero_vc", vc_w[3], 32'h0);
        @(negedge clk);
        check("t4_zero_ready_drop", 32'(rdy[3]), 32'h0);
        rc_in[3] = '0;

        // Reset mid-RUN: SEQ at idx=1, PAR with mask=0101.
        @(negedge clk);
        v_in[0] = 1'b1; it_in[0] = 8'd1; v_in[1] = 1'b1; it_in[1] = 8'd1;
        @(negedge clk);
        v_in[0] = 1'b0; v_in[1] = 1'b0;
        rc_in[0] = 32'h1; rc_in[1] = 32'h5;
        @(negedge clk);
        check("t5_seq_idx1", vc_w[0], 32'h2);
        check("t5_par_mask0101", vc_w[1], 32'ha);
        rc_in[0] = '0; rc_in[1] = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_seq_vc_after_reset", vc_w[0], 32'h0);
        check("t5_par_vc_after_reset", vc_w[1], 32'h0);
        check("t5_ready_after_reset", 32'(rdy), 32'h0);
        @(negedge clk);
        check("t5_no_late_ready", 32'(rdy), 32'h0);
        v_in[0] = 1'b1; it_in[0] = 8'd1;
        @(negedge clk); v_in[0] = 1'b0;
        check("t5_restart_child0", vc_w[0], 32'h1);
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            if (rdy[0]) begin
                seen = 1'b1;
                check("t5_restart_ready_cycle", 32'(c), 32'd4);
            end
            rc_in[0] = vc_w[0];
            @(negedge clk);
        end
        if (!seen) check("t5_restart_timeout", 32'h0, 32'h1);
        rc_in[0] = '0;

        // PAR N=2, iters=2, valid held for three back-to-back groups.
        @(negedge clk); v_in[3] = 1'b1; it_in[3] = 8'd2;
        pulses = 0;
        for (int c = 1; c <= 40 && pulses < 3; c++) begin
            @(negedge clk);
            rc_in[3] = vc_w[3];
            if (rdy[3]) begin
                check($sformatf("t6_pulse%0d_cycle", pulses), 32'(c), 32'(t6_exp[pulses]));
                pulses++;
                if (pulses == 3) v_in[3] = 1'b0;
            end
        end
        check("t6_pulse_count", 32'(pulses), 32'd3);
        rc_in[3] = '0;
        repeat (3) @(negedge clk);
        check("t6_idle_after", vc_w[3], 32'h0);

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
